// File: rtl/wb_retire_queue_pkg.sv
// -----------------------------------------------------------------------------
// wb_retire_queue_pkg
// Purpose : shared types and constants for the write-back retire queue.
//   DATA_W_DEF / ADDR_W_DEF : default result/PC width and RF address width
//   wb_entry_t              : one queued retire entry at the default widths
//   ptr_w()                 : index width (without wrap bit) for a given depth
// Ports   : none (package)
// -----------------------------------------------------------------------------
package wb_retire_queue_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] pc;
    logic                  gr_we;
    logic [ADDR_W_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0] result;
    logic                  ex;
  } wb_entry_t;

  // Index bits for a power-of-two depth; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/wb_retire_queue_if.sv
// -----------------------------------------------------------------------------
// wb_retire_queue_if
// Purpose : memory-stage -> write-back handshake bundle.
//   ms_valid   upstream entry valid          ws_allowin  queue can accept
//   ms_pc      entry PC                      ms_gr_we    entry writes the RF
//   ms_dest    RF destination                ms_result   write data
//   ms_ex      entry carries an exception
// Modports: master (memory stage), slave (retire queue).
// -----------------------------------------------------------------------------
interface wb_retire_queue_if
  import wb_retire_queue_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              ms_valid;
  logic              ws_allowin;
  logic [DATA_W-1:0] ms_pc;
  logic              ms_gr_we;
  logic [ADDR_W-1:0] ms_dest;
  logic [DATA_W-1:0] ms_result;
  logic              ms_ex;

  modport master (
    output ms_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_ex,
    input  ws_allowin
  );

  modport slave (
    input  ms_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_ex,
    output ws_allowin
  );

endinterface

// File: rtl/wb_fw_lookup.sv
// -----------------------------------------------------------------------------
// wb_fw_lookup
// Purpose : forwarding match over the queue contents, youngest entry wins.
//   elig_i  [DEPTH]      entry may forward (age order, index 0 = oldest)
//   dest_i  [DEPTH]      entry RF destination
//   res_i   [DEPTH]      entry result
//   raddr_i              lookup register number
//   hit_o / data_o       match flag and youngest matching result (comb.)
// -----------------------------------------------------------------------------
module wb_fw_lookup
  import wb_retire_queue_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 2
) (
  input  logic [DEPTH-1:0]             elig_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] dest_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] res_i,
  input  logic [ADDR_W-1:0]            raddr_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);

  // Later (younger) matches overwrite earlier ones; r0 never matches.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (elig_i[k] && (dest_i[k] == raddr_i) && (raddr_i != '0)) begin
        hit_o  = 1'b1;
        data_o = res_i[k];
      end
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// -----------------------------------------------------------------------------
// wb_retire_queue
// Purpose : write-back stage retire FIFO. Entries from the memory stage are
//           queued and retired in order, one per cycle, driving the register
//           file write port or raising an exception pulse. Provides RF
//           forwarding from queued entries.
// Ports   :
//   clk, reset                 clock, synchronous active-high reset
//   ms_if (slave)              memory-stage handshake and entry payload
//   flush                      discard all entries, suppress this cycle's retire
//   rf_we/rf_waddr/rf_wdata    register-file write port
//   fw_raddr0/1 -> fw_hit0/1, fw_data0/1   forwarding lookups
//   ws_ex, ws_ex_pc            exception retire pulse and its PC
//   debug_wb_*                 retire trace (only with WB_DEBUG_TRACE_EN)
// Build   : define WB_DEBUG_TRACE_EN to add the debug trace ports.
// -----------------------------------------------------------------------------
module wb_retire_queue
  import wb_retire_queue_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  wb_retire_queue_if.slave  ms_if,
  input  logic              flush,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] fw_raddr0,
  input  logic [ADDR_W-1:0] fw_raddr1,
  output logic              fw_hit0,
  output logic              fw_hit1,
  output logic [DATA_W-1:0] fw_data0,
  output logic [DATA_W-1:0] fw_data1,
  output logic              ws_ex,
  output logic [DATA_W-1:0] ws_ex_pc
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [DATA_W-1:0] debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
`endif
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic              gr_we;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] result;
    logic              ex;
  } entry_t;

  logic [CW-1:0]    head_q, head_d;
  logic [CW-1:0]    tail_q, tail_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  entry_t           mem_q [DEPTH];

  logic [PW-1:0] head_idx, tail_idx;
  logic          empty, full, head_vld;
  logic          retire, ex_retire, push;
  entry_t        head_ent, in_ent;

  assign head_idx = head_q[PW-1:0];
  assign tail_idx = tail_q[PW-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[PW] != tail_q[PW]);
  assign head_vld = ~empty;
  assign head_ent = mem_q[head_idx];

  // Flush suppresses the retire; an exception retire also swallows the push.
  assign retire           = head_vld & ~flush;
  assign ex_retire        = retire & head_ent.ex;
  assign ms_if.ws_allowin = ~full | retire;
  assign push             = ms_if.ms_valid & ms_if.ws_allowin & ~flush & ~ex_retire;

  always_comb begin
    in_ent        = '0;
    in_ent.pc     = ms_if.ms_pc;
    in_ent.gr_we  = ms_if.ms_gr_we;
    in_ent.dest   = ms_if.ms_dest;
    in_ent.result = ms_if.ms_result;
    in_ent.ex     = ms_if.ms_ex;
  end

  // Retire outputs; payload is unreset so everything is gated by occupancy.
  assign rf_we    = retire & ~head_ent.ex & head_ent.gr_we & (head_ent.dest != '0);
  assign rf_waddr = head_vld ? head_ent.dest   : '0;
  assign rf_wdata = head_vld ? head_ent.result : '0;
  assign ws_ex    = ex_retire;
  assign ws_ex_pc = ex_retire ? head_ent.pc : '0;

  // Pointer / valid next state; push is applied after retire so a full
  // queue that pushes and retires into the same slot keeps it valid.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d  = vld_q;
    if (flush || ex_retire) begin
      head_d = '0;
      tail_d = '0;
      vld_d  = '0;
    end else begin
      if (retire) begin
        vld_d[head_idx] = 1'b0;
        head_d          = head_q + CW'(1);
      end
      if (push) begin
        vld_d[tail_idx] = 1'b1;
        tail_d          = tail_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
    end
  end

  // Payload storage, deliberately without reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_idx] <= in_ent;
    end
  end

  // Age-ordered view for forwarding; anything behind a queued exception
  // will be discarded, so it must not forward.
  logic [DEPTH-1:0]             fw_elig;
  logic [DEPTH-1:0][ADDR_W-1:0] fw_dest;
  logic [DEPTH-1:0][DATA_W-1:0] fw_res;
  logic [PW-1:0]                slot;
  logic                         blocked;

  always_comb begin
    fw_elig = '0;
    fw_dest = '0;
    fw_res  = '0;
    slot    = '0;
    blocked = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      slot       = head_idx + PW'(k);
      fw_dest[k] = mem_q[slot].dest;
      fw_res[k]  = mem_q[slot].result;
      fw_elig[k] = vld_q[slot] & ~blocked & ~mem_q[slot].ex & mem_q[slot].gr_we;
      if (vld_q[slot] && mem_q[slot].ex) begin
        blocked = 1'b1;
      end
    end
  end

  wb_fw_lookup #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fw0 (
    .elig_i  (fw_elig),
    .dest_i  (fw_dest),
    .res_i   (fw_res),
    .raddr_i (fw_raddr0),
    .hit_o   (fw_hit0),
    .data_o  (fw_data0)
  );

  wb_fw_lookup #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fw1 (
    .elig_i  (fw_elig),
    .dest_i  (fw_dest),
    .res_i   (fw_res),
    .raddr_i (fw_raddr1),
    .hit_o   (fw_hit1),
    .data_o  (fw_data1)
  );

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = head_vld ? head_ent.pc : '0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_retire_queue
// Purpose : self-checking bench for wb_retire_queue (DEPTH=2). Directed table
//           of per-cycle stimulus with hand-derived outputs, a reset/wrap
//           sequence, and a randomized phase, all shadowed by a queue model.
// -----------------------------------------------------------------------------
module tb_wb_retire_queue;
  import wb_retire_queue_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fw_raddr0, fw_raddr1;
  logic        fw_hit0, fw_hit1;
  logic [31:0] fw_data0, fw_data1;
  logic        ws_ex;
  logic [31:0] ws_ex_pc;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  wb_retire_queue_if ms_if ();

  wb_retire_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .ms_if     (ms_if),
    .flush     (flush),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .fw_raddr0 (fw_raddr0),
    .fw_raddr1 (fw_raddr1),
    .fw_hit0   (fw_hit0),
    .fw_hit1   (fw_hit1),
    .fw_data0  (fw_data0),
    .fw_data1  (fw_data1),
    .ws_ex     (ws_ex),
    .ws_ex_pc  (ws_ex_pc)
`ifdef WB_DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, we, ex, fl;
    logic [4:0]  dest, ra0, ra1;
    logic [31:0] res, pc;
  } stim_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ex;
    logic [31:0] expc;
    logic        allow, h0;
    logic [31:0] d0;
    logic        h1;
    logic [31:0] d1;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } rec_t;

  int total = 0;
  int bad   = 0;
  rec_t tab[$];
  wb_entry_t sb[$];

  function automatic stim_t st(logic v, logic we, logic ex, logic [4:0] dest,
                               logic [31:0] res, logic [31:0] pc, logic fl,
                               logic [4:0] ra0, logic [4:0] ra1);
    stim_t s;
    s.v = v; s.we = we; s.ex = ex; s.dest = dest; s.res = res; s.pc = pc;
    s.fl = fl; s.ra0 = ra0; s.ra1 = ra1;
    return s;
  endfunction

  function automatic exp_t xp(logic we, logic [4:0] waddr, logic [31:0] wdata,
                              logic ex, logic [31:0] expc, logic allow,
                              logic h0, logic [31:0] d0, logic h1, logic [31:0] d1);
    exp_t e;
    e.we = we; e.waddr = waddr; e.wdata = wdata; e.ex = ex; e.expc = expc;
    e.allow = allow; e.h0 = h0; e.d0 = d0; e.h1 = h1; e.d1 = d1;
    return e;
  endfunction

  task automatic add(input stim_t s, input exp_t e);
    rec_t r;
    r.s = s;
    r.e = e;
    tab.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    ms_if.ms_valid  = s.v;
    ms_if.ms_gr_we  = s.we;
    ms_if.ms_ex     = s.ex;
    ms_if.ms_dest   = s.dest;
    ms_if.ms_result = s.res;
    ms_if.ms_pc     = s.pc;
    flush           = s.fl;
    fw_raddr0       = s.ra0;
    fw_raddr1       = s.ra1;
  endtask

  // Reference forwarding: youngest eligible entry, nothing behind an exception.
  task automatic fw_model(input logic [4:0] ra, output logic hit, output logic [31:0] data);
    logic blk;
    hit  = 1'b0;
    data = '0;
    blk  = 1'b0;
    for (int i = 0; i < sb.size(); i++) begin
      if (!blk && !sb[i].ex && sb[i].gr_we && sb[i].dest != 0 && sb[i].dest == ra && ra != 0) begin
        hit  = 1'b1;
        data = sb[i].result;
      end
      if (sb[i].ex) blk = 1'b1;
    end
  endtask

  // Scoreboard check against current outputs, then advance the model.
  task automatic model_cycle(input string tag);
    wb_entry_t   h, n;
    logic        ret, e_we, e_ex, allow, h0, h1;
    logic [31:0] d0, d1;
    h    = '0;
    ret  = (sb.size() > 0) && !flush;
    e_we = 1'b0;
    e_ex = 1'b0;
    if (ret) begin
      h    = sb[0];
      e_ex = h.ex;
      e_we = !h.ex && h.gr_we && (h.dest != 0);
    end
    allow = (sb.size() < DEPTH) || ret;
    if (!reset) begin
      chk({tag, " sb rf_we"}, 32'(rf_we), 32'(e_we));
      if (e_we) begin
        chk({tag, " sb rf_waddr"}, 32'(rf_waddr), 32'(h.dest));
        chk({tag, " sb rf_wdata"}, rf_wdata, h.result);
      end
      chk({tag, " sb ws_ex"}, 32'(ws_ex), 32'(e_ex));
      if (e_ex) chk({tag, " sb ws_ex_pc"}, ws_ex_pc, h.pc);
      chk({tag, " sb ws_allowin"}, 32'(ms_if.ws_allowin), 32'(allow));
      fw_model(fw_raddr0, h0, d0);
      fw_model(fw_raddr1, h1, d1);
      chk({tag, " sb fw_hit0"}, 32'(fw_hit0), 32'(h0));
      if (h0 || fw_raddr0 == 0) chk({tag, " sb fw_data0"}, fw_data0, d0);
      chk({tag, " sb fw_hit1"}, 32'(fw_hit1), 32'(h1));
      if (h1 || fw_raddr1 == 0) chk({tag, " sb fw_data1"}, fw_data1, d1);
    end
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (ret) begin
        void'(sb.pop_front());
        if (h.ex) sb.delete();
      end
      if (ms_if.ms_valid && allow && !(ret && h.ex)) begin
        n.pc = ms_if.ms_pc; n.gr_we = ms_if.ms_gr_we; n.dest = ms_if.ms_dest;
        n.result = ms_if.ms_result; n.ex = ms_if.ms_ex;
        sb.push_back(n);
      end
    end
  endtask

  task automatic step(input stim_t s, input string tag);
    drive(s);
    #2;
    model_cycle(tag);
    @(posedge clk);
    #1;
  endtask

  stim_t idle;

  initial begin
    idle  = st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cycles: stimulus, then outputs expected during that cycle.
    add(st(0,0,0,0,0,0,0,0,0),                    xp(0,0,0,0,0,1,0,0,0,0));
    add(st(1,1,0,5,32'hDEADBEEF,32'h1c000000,0,5,0), xp(0,0,0,0,0,1,0,0,0,0));
    add(st(0,0,0,0,0,0,0,5,0),                    xp(1,5,32'hDEADBEEF,0,0,1,1,32'hDEADBEEF,0,0));
    add(st(0,0,0,0,0,0,0,5,0),                    xp(0,0,0,0,0,1,0,0,0,0));
    add(st(1,1,0,1,32'h11,32'h10,0,0,0),          xp(0,0,0,0,0,1,0,0,0,0));
    add(st(1,1,0,2,32'h22,32'h14,0,0,0),          xp(1,1,32'h11,0,0,1,0,0,0,0));
    add(st(1,1,0,3,32'h33,32'h18,0,0,0),          xp(1,2,32'h22,0,0,1,0,0,0,0));
    add(st(0,0,0,0,0,0,0,0,0),                    xp(1,3,32'h33,0,0,1,0,0,0,0));
    add(st(0,0,0,0,0,0,0,0,0),                    xp(0,0,0,0,0,1,0,0,0,0));
    add(st(1,1,0,7,32'h1,32'h20,0,7,0),           xp(0,0,0,0,0,1,0,0,0,0));
    add(st(1,1,0,7,32'h2,32'h24,0,7,0),           xp(1,7,32'h1,0,0,1,1,32'h1,0,0));
    add(st(0,0,0,0,0,0,0,7,0),                    xp(1,7,32'h2,0,0,1,1,32'h2,0,0));
    add(st(0,0,0,0,0,0,0,7,0),                    xp(0,0,0,0,0,1,0,0,0,0));
    add(st(1,1,1,9,32'h99,32'h100,0,9,0),         xp(0,0,0,0,0,1,0,0,0,0));
    add(st(1,1,0,3,32'h33,32'h104,0,9,3),         xp(0,0,0,1,32'h100,1,0,0,0,0));
    add(st(0,0,0,0,0,0,0,0,3),                    xp(0,0,0,0,0,1,0,0,0,0));
    add(st(1,1,0,4,32'h44,32'h30,0,4,0),          xp(0,0,0,0,0,1,0,0,0,0));
    add(st(1,1,0,6,32'h66,32'h34,1,4,0),          xp(0,0,0,0,0,1,1,32'h44,0,0));
    add(st(0,0,0,0,0,0,0,6,0),                    xp(0,0,0,0,0,1,0,0,0,0));
    add(st(1,0,1,0,32'h0,32'h200,0,0,0),          xp(0,0,0,0,0,1,0,0,0,0));
    add(st(0,0,0,0,0,0,1,0,0),                    xp(0,0,0,0,0,1,0,0,0,0));
    add(st(0,0,0,0,0,0,0,0,0),                    xp(0,0,0,0,0,1,0,0,0,0));
    add(st(1,1,0,0,32'h77,32'h40,0,0,0),          xp(0,0,0,0,0,1,0,0,0,0));
    add(st(0,0,0,0,0,0,0,0,0),                    xp(0,0,0,0,0,1,0,0,0,0));
    add(st(1,0,0,8,32'h88,32'h44,0,0,0),          xp(0,0,0,0,0,1,0,0,0,0));
    add(st(0,0,0,0,0,0,0,8,0),                    xp(0,0,0,0,0,1,0,0,0,0));

    for (int i = 0; i < tab.size(); i++) begin
      string t;
      t = $sformatf("row%0d", i);
      drive(tab[i].s);
      #2;
      chk({t, " rf_we"}, 32'(rf_we), 32'(tab[i].e.we));
      if (tab[i].e.we) begin
        chk({t, " rf_waddr"}, 32'(rf_waddr), 32'(tab[i].e.waddr));
        chk({t, " rf_wdata"}, rf_wdata, tab[i].e.wdata);
      end
      chk({t, " ws_ex"}, 32'(ws_ex), 32'(tab[i].e.ex));
      if (tab[i].e.ex) chk({t, " ws_ex_pc"}, ws_ex_pc, tab[i].e.expc);
      chk({t, " ws_allowin"}, 32'(ms_if.ws_allowin), 32'(tab[i].e.allow));
      chk({t, " fw_hit0"}, 32'(fw_hit0), 32'(tab[i].e.h0));
      if (tab[i].e.h0 || tab[i].s.ra0 == 0) chk({t, " fw_data0"}, fw_data0, tab[i].e.d0);
      chk({t, " fw_hit1"}, 32'(fw_hit1), 32'(tab[i].e.h1));
      if (tab[i].e.h1 || tab[i].s.ra1 == 0) chk({t, " fw_data1"}, fw_data1, tab[i].e.d1);
      model_cycle(t);
      @(posedge clk);
      #1;
    end

    // Reset while an entry is queued and another is being pushed.
    step(st(1,1,0,10,32'hA0,32'h500,0,0,0), "rst_pre");
    reset = 1'b1;
    step(st(1,1,0,11,32'hB0,32'h504,0,10,11), "rst_cyc");
    reset = 1'b0;
    drive(st(0,0,0,0,0,0,0,10,11));
    #2;
    chk("post_rst rf_we", 32'(rf_we), 32'h0);
    chk("post_rst fw_hit0", 32'(fw_hit0), 32'h0);
    chk("post_rst fw_hit1", 32'(fw_hit1), 32'h0);
    chk("post_rst ws_allowin", 32'(ms_if.ws_allowin), 32'h1);
    chk("post_rst ws_ex", 32'(ws_ex), 32'h0);
    model_cycle("post_rst");
    @(posedge clk);
    #1;

    // 2*DEPTH back-to-back pushes across the pointer wrap, then drain.
    for (int i = 0; i < 2 * int'(DEPTH); i++) begin
      step(st(1,1,0,5'(12 + i),32'hC0 + 32'(i),32'h600 + 32'(4 * i),0,5'(12 + i),0),
           $sformatf("wrap%0d", i));
    end
    step(idle, "wrap_drain");
    chk("wrap empty rf_we", 32'(rf_we), 32'h0);

    // Randomized traffic with small register numbers to provoke forwarding.
    for (int i = 0; i < 400; i++) begin
      stim_t s;
      s = st($urandom_range(99, 0) < 70, $urandom_range(1, 0) == 1,
             $urandom_range(99, 0) < 10, 5'($urandom_range(7, 0)),
             $urandom, $urandom, $urandom_range(99, 0) < 5,
             5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
      reset = ($urandom_range(99, 0) < 2);
      step(s, $sformatf("rnd%0d", i));
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_retire_queue.md
WB_RETIRE_QUEUE -- requirements
Module: wb_retire_queue

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 32, result/PC width; ADDR_W, 5, RF address width; DEPTH, 2, entries (power of two, 2..8).
REQ-002 Ports (name direction width meaning): clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-003 ms_valid in 1 upstream entry valid; ws_allowin out 1 queue can accept this cycle.
REQ-004 ms_pc in DATA_W; ms_gr_we in 1; ms_dest in ADDR_W; ms_result in DATA_W; ms_ex in 1 exception flag.
REQ-005 rf_we out 1; rf_waddr out ADDR_W; rf_wdata out DATA_W: register-file write port.
REQ-006 fw_raddr0/fw_raddr1 in ADDR_W forwarding lookups; fw_hit0/fw_hit1 out 1; fw_data0/fw_data1 out DATA_W.
REQ-007 ws_ex out 1 exception retire pulse; ws_ex_pc out DATA_W; flush in 1 external pipeline flush.
REQ-008 debug_wb_pc out DATA_W; debug_wb_rf_we out 4; debug_wb_rf_wnum out ADDR_W; debug_wb_rf_wdata out DATA_W (present only per REQ-024).

Function
REQ-009 Circular FIFO of DEPTH entries {pc, gr_we, dest, result, ex}; head/tail pointers log2(DEPTH) bits plus wrap bit.
REQ-010 ws_allowin = !full | retire_this_cycle; push when ms_valid & ws_allowin & !flush.
REQ-011 Retire one head entry per cycle when non-empty; latency push->retire minimum 1 cycle (registered).
REQ-012 Retire of non-ex entry: rf_we = gr_we & (dest != 0), rf_waddr = dest, rf_wdata = result, same cycle head valid.
REQ-013 Retire of ex entry: rf_we=0, ws_ex=1 for exactly one cycle, ws_ex_pc = entry pc; all younger entries discarded next cycle.
REQ-014 After ex retire, incoming pushes in that same cycle are dropped; queue empty next cycle.
REQ-015 flush=1: queue empty next cycle, no retire, rf_we=0 and ws_ex=0 that cycle.
REQ-016 Simultaneous push and retire when full: both occur; occupancy unchanged.
REQ-017 Pointer wrap at DEPTH: full when indices equal and wrap bits differ; empty when both equal.
REQ-018 Forwarding: fw_hitN=1 iff some valid non-ex entry with gr_we, dest==fw_raddrN, dest!=0; fw_dataN = youngest matching entry's result; combinational.
REQ-019 fw_raddrN==0: fw_hitN=0, fw_dataN=0.
REQ-020 Entries younger than a queued ex entry are excluded from forwarding.

Reset
REQ-021 reset: head=tail=0, all entry valid bits 0; next-cycle outputs rf_we=0, ws_ex=0, ws_allowin=1, fw_hit*=0.
REQ-022 reset mid-operation discards all entries without RF write; reset has priority over flush and push.
REQ-023 Entry payload registers need not be reset; outputs derived from them are gated by valid.

Configuration
REQ-024 Macro WB_DEBUG_TRACE_EN: defined -> debug ports present, debug_wb_pc=head pc, debug_wb_rf_we={4{rf_we}}, wnum/wdata mirror rf_waddr/rf_wdata; undefined -> debug ports and logic absent, function otherwise identical.

Structure
REQ-025 Shared package holds entry struct type, default width constants (DATA_W, ADDR_W) and pointer-width function.
REQ-026 One sub-module wb_fw_lookup: parallel compare plus youngest-priority select, instantiated twice.

Verification
REQ-027 Single push pc=0x1c000000, dest=5, result=0xDEADBEEF, gr_we=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-028 DEPTH=2, stall retire impossible so push 3 back-to-back while holding ms_valid -> ws_allowin stays 1, three writes in order, no loss.
REQ-029 Queue holds dest=7 result=1 then dest=7 result=2; fw_raddr0=7 -> fw_hit0=1, fw_data0=2; fw_raddr1=0 -> fw_hit1=0.
REQ-030 Entry ex=1 pc=0x100 followed by entry dest=3 -> ws_ex pulse with ws_ex_pc=0x100, no write to r3, queue empty next cycle.
REQ-031 flush asserted with 2 entries queued -> no rf_we that cycle, empty next cycle, ws_allowin=1.
REQ-032 reset asserted with full queue -> rf_we=0 following cycle, fw_hit0=fw_hit1=0, pointer wrap correct on subsequent 2*DEPTH pushes.
